morph_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the 5x5 binary morphology stage between binarize and the motion-box logic.

---
 rtl/morph_pkg.sv | 22 ++
 rtl/morph_frame_ctrl_if.sv | 22 ++
 rtl/morph_pos_cnt.sv | 32 +++
 rtl/morph_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_morph_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/morph_pkg.sv
// Shared encodings for the 5x5 morphology frame sequencer.
package morph_pkg;

  localparam int WIN_RADIUS_DEF = 2;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_ERODE  = 2'd1;
  localparam logic [1:0] MODE_DILATE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACTIVE,
    ST_DONE
  } frm_state_t;

  // The reserved encoding runs the stage as a pass-through.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_BYPASS : m;
  endfunction

endpackage

// File: rtl/morph_frame_ctrl_if.sv
// Pixel-stream timing in, delayed timing plus position/border info out.
interface morph_frame_ctrl_if;
  logic       in_vsync;
  logic       in_href;
  logic       in_clken;
  logic       ctl_vsync;
  logic       ctl_href;
  logic       ctl_clken;
  logic       border_mask;
  logic [9:0] col_cnt;
  logic [9:0] row_cnt;

  modport slave (
    input  in_vsync, in_href, in_clken,
    output ctl_vsync, ctl_href, ctl_clken, border_mask, col_cnt, row_cnt
  );

  modport master (
    output in_vsync, in_href, in_clken,
    input  ctl_vsync, ctl_href, ctl_clken, border_mask, col_cnt, row_cnt
  );
endinterface

// File: rtl/morph_pos_cnt.sv
// Column/row position counters with a line-length check at each line end.
module morph_pos_cnt #(
  parameter logic [9:0] IMG_HDISP = 10'd640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       clr,
  input  logic       pix,
  input  logic       hr_fall,
  output logic [9:0] col_cnt,
  output logic [9:0] row_cnt,
  output logic       line_err
);

  assign line_err = cnt_en & hr_fall & (col_cnt != IMG_HDISP);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (cnt_en) begin
      if (hr_fall) begin
        col_cnt <= '0;
        if (row_cnt != 10'h3FF) row_cnt <= row_cnt + 10'd1;
      end else if (pix && col_cnt != 10'h3FF) begin
        col_cnt <= col_cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer: per-frame config latch, border mask generation and
// malformed-frame detection for the 5x5 binary morphology stage.
module morph_frame_ctrl
  import morph_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP  = 10'd640,
  parameter logic [9:0] IMG_VDISP  = 10'd480,
  parameter int         WIN_RADIUS = WIN_RADIUS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_mode,
  input  logic       cfg_bval,
  input  logic       cfg_wr,
  input  logic       err_clr,
  morph_frame_ctrl_if.slave vid,
  output logic [1:0] op_mode,
  output logic       border_val,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       err_line,
  output logic       err_frame
);

  localparam logic [9:0] R = 10'(WIN_RADIUS);

  frm_state_t state, state_nxt;
  logic       vs_d, hr_d;
  logic       vs_rise, hr_fall, pix;
  logic [1:0] shadow_mode;
  logic       shadow_bval;
  logic       done_set, frm_err_set;
  logic       line_err;
  logic       cnt_en;
  logic       mask_c;

  assign vs_rise = vid.in_vsync & ~vs_d;
  assign hr_fall = ~vid.in_href & hr_d;
  assign pix     = vid.in_href & vid.in_clken;

  assign cnt_en     = (state == ST_ARMED) || (state == ST_ACTIVE);
  assign frame_busy = cnt_en;

  morph_pos_cnt #(.IMG_HDISP(IMG_HDISP)) u_pos (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .clr     (vs_rise),
    .pix     (pix),
    .hr_fall (hr_fall),
    .col_cnt (vid.col_cnt),
    .row_cnt (vid.row_cnt),
    .line_err(line_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    done_set    = 1'b0;
    frm_err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_rise) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (vs_rise)  state_nxt = ST_ARMED;
        else if (pix) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          state_nxt   = ST_ARMED;
          frm_err_set = 1'b1;
        end else if (hr_fall && vid.row_cnt == IMG_VDISP - 10'd1) begin
          state_nxt = ST_DONE;
          done_set  = 1'b1;
        end
      end
      ST_DONE: begin
        if (vs_rise)  state_nxt   = ST_ARMED;
        else if (pix) frm_err_set = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outside a frame every pixel is treated as border so downstream never
  // filters with a half-valid window.
  always_comb begin
    mask_c = 1'b1;
    if (cnt_en)
      mask_c = (vid.col_cnt < R) || (vid.col_cnt >= IMG_HDISP - R) ||
               (vid.row_cnt < R) || (vid.row_cnt >= IMG_VDISP - R);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d            <= 1'b1;
      hr_d            <= 1'b0;
      shadow_mode     <= MODE_BYPASS;
      shadow_bval     <= 1'b0;
      op_mode         <= MODE_BYPASS;
      border_val      <= 1'b0;
      vid.ctl_vsync   <= 1'b0;
      vid.ctl_href    <= 1'b0;
      vid.ctl_clken   <= 1'b0;
      vid.border_mask <= 1'b0;
      frame_done      <= 1'b0;
      err_line        <= 1'b0;
      err_frame       <= 1'b0;
    end else begin
      vs_d <= vid.in_vsync;
      hr_d <= vid.in_href;
      if (cfg_wr) begin
        shadow_mode <= cfg_mode;
        shadow_bval <= cfg_bval;
      end
      // A write landing on the frame edge applies to that frame.
      if (vs_rise) begin
        op_mode    <= norm_mode(cfg_wr ? cfg_mode : shadow_mode);
        border_val <= cfg_wr ? cfg_bval : shadow_bval;
      end
      vid.ctl_vsync   <= vid.in_vsync;
      vid.ctl_href    <= vid.in_href;
      vid.ctl_clken   <= vid.in_clken;
      vid.border_mask <= mask_c;
      frame_done      <= done_set;
      err_line        <= line_err | (err_line & ~err_clr);
      err_frame       <= frm_err_set | (err_frame & ~err_clr);
    end
  end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Scoreboard bench for morph_frame_ctrl on a 16x8 image.
module tb_morph_frame_ctrl;

  typedef struct {
    logic       mask;
    logic [1:0] mode;
    int         r;
    int         c;
  } pix_t;

  typedef struct {
    string       nm;
    logic [28:0] v;
  } stat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_mode;
  logic       cfg_bval, cfg_wr, err_clr;
  logic [1:0] op_mode;
  logic       border_val, frame_busy, frame_done, err_line, err_frame;

  morph_frame_ctrl_if vif();

  morph_frame_ctrl #(
    .IMG_HDISP (10'd16),
    .IMG_VDISP (10'd8),
    .WIN_RADIUS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .cfg_bval  (cfg_bval),
    .cfg_wr    (cfg_wr),
    .err_clr   (err_clr),
    .vid       (vif),
    .op_mode   (op_mode),
    .border_val(border_val),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .err_line  (err_line),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  pix_t  pix_q[$];
  stat_t stat_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    stim_end = 0;
  bit    mon_fin = 0;

  // Bench-side model of what the DUT should show.
  logic       e_busy, e_line, e_frame, e_bval;
  logic [1:0] e_mode, sh_mode;
  logic       sh_bval;
  int         e_row;

  always @(negedge clk) begin
    pix_t        p;
    stat_t       s;
    logic [28:0] act;
    if (vif.ctl_href && vif.ctl_clken) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: output pixel with empty scoreboard");
      end else begin
        p = pix_q.pop_front();
        if ({vif.border_mask, op_mode} !== {p.mask, p.mode}) begin
          errors++;
          $display("FAIL pix r%0d c%0d: mask/mode got %b/%0d exp %b/%0d",
                   p.r, p.c, vif.border_mask, op_mode, p.mask, p.mode);
        end
      end
    end
    while (stat_q.size() > 0) begin
      s   = stat_q.pop_front();
      act = {frame_busy, frame_done, err_line, err_frame, vif.border_mask,
             vif.ctl_vsync, border_val, op_mode, vif.col_cnt, vif.row_cnt};
      checks++;
      if (act !== s.v) begin
        errors++;
        $display("FAIL %s: {busy,done,eline,eframe,mask,cvs,bval,mode,col,row} got %h exp %h",
                 s.nm, act, s.v);
      end
    end
    if (stim_end && !mon_fin) begin
      checks++;
      if (pix_q.size() != 0) begin
        errors++;
        $display("FAIL pix_drain: %0d expected pixels never came out", pix_q.size());
      end
      mon_fin = 1;
    end
  end

  function automatic bit bmask(int c, int r);
    return (c < 2) || (c >= 14) || (r < 2) || (r >= 6);
  endfunction

  task automatic push_stat(string nm, bit done, int col, int row, bit mask, bit cvs);
    stat_t s;
    s.nm = nm;
    s.v  = {e_busy, done, e_line, e_frame, mask, cvs, e_bval, e_mode,
            10'(col), 10'(row)};
    stat_q.push_back(s);
  endtask

  task automatic cyc(bit v, bit h, bit c, bit wr = 0, bit clr = 0);
    vif.in_vsync = v;
    vif.in_href  = h;
    vif.in_clken = c;
    cfg_wr       = wr;
    err_clr      = clr;
    @(posedge clk);
    #1;
    cfg_wr  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic cfg_pulse(logic [1:0] m, bit b);
    cfg_mode = m;
    cfg_bval = b;
    sh_mode  = m;
    sh_bval  = b;
    cyc(0, 0, 0, 1, 0);
    push_stat("cfg_hold", 0, 0, e_row, 1, 0);
  endtask

  task automatic clr_pulse();
    e_line  = 0;
    e_frame = 0;
    cyc(0, 0, 0, 0, 1);
    push_stat("err_clr", 0, 0, e_row, 1, 0);
  endtask

  task automatic start_frame(bit wr, logic [1:0] m, bit b, bit restart);
    if (wr) begin
      cfg_mode = m;
      cfg_bval = b;
      sh_mode  = m;
      sh_bval  = b;
    end
    e_mode = (sh_mode == 2'd3) ? 2'd0 : sh_mode;
    e_bval = sh_bval;
    if (restart) e_frame = 1;
    e_busy = 1;
    e_row  = 0;
    cyc(1, 0, 0, wr, 0);
    push_stat(restart ? "vs_restart" : "vs_rise", 0, 0, 0, 1, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  // kind: 0 normal line, 1 last line of frame, 2 stray line after frame end
  task automatic send_line(int n, int kind);
    pix_t p;
    for (int c = 0; c < n; c++) begin
      p.mask = (kind == 2) ? 1'b1 : bmask(c, e_row);
      p.mode = e_mode;
      p.r    = e_row;
      p.c    = c;
      pix_q.push_back(p);
      cyc(0, 1, 1);
      if (kind == 2) e_frame = 1;
      if (c == 4)
        push_stat("mid_line", 0, (kind == 2) ? 0 : 5, e_row,
                  (kind == 2) ? 1'b1 : bmask(4, e_row), 0);
    end
    cyc(0, 0, 0);
    if (kind != 2) begin
      if (n != 16) e_line = 1;
      e_row++;
      if (kind == 1) e_busy = 0;
    end
    push_stat("line_end", kind == 1, 0, e_row, 1, 0);
    cyc(0, 0, 0);
    push_stat("line_gap", 0, 0, e_row, 1, 0);
    cyc(0, 0, 0);
  endtask

  initial begin
    rst = 1; cfg_mode = 0; cfg_bval = 0; cfg_wr = 0; err_clr = 0;
    vif.in_vsync = 0; vif.in_href = 0; vif.in_clken = 0;
    e_busy = 0; e_line = 0; e_frame = 0; e_bval = 0; e_mode = 0;
    sh_mode = 0; sh_bval = 0; e_row = 0;
    repeat (3) @(posedge clk);
    #1;
    push_stat("reset", 0, 0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0);
    push_stat("idle", 0, 0, 0, 1, 0);

    // Frame 1: config written while idle takes effect at frame start.
    cfg_pulse(2'd1, 1'b1);
    start_frame(0, 0, 0, 0);
    for (int r = 0; r < 8; r++) send_line(16, (r == 7) ? 1 : 0);

    // Frame 2: mid-frame config change, short line on row 3.
    start_frame(0, 0, 0, 0);
    send_line(16, 0);
    send_line(16, 0);
    cfg_pulse(2'd2, 1'b0);
    send_line(16, 0);
    send_line(15, 0);
    clr_pulse();
    for (int r = 4; r < 8; r++) send_line(16, (r == 7) ? 1 : 0);

    // Frame 3: restart at row 4 with a write-through of the reserved mode.
    start_frame(0, 0, 0, 0);
    for (int r = 0; r < 4; r++) send_line(16, 0);
    start_frame(1, 2'd3, 1'b0, 1);
    clr_pulse();
    for (int r = 0; r < 8; r++) send_line(16, (r == 7) ? 1 : 0);
    send_line(16, 2);

    // Frame 4: reset lands in row 5 with vsync held high.
    cfg_pulse(2'd1, 1'b1);
    start_frame(0, 0, 0, 0);
    for (int r = 0; r < 5; r++) send_line(16, 0);
    rst = 1;
    vif.in_vsync = 1; vif.in_href = 1; vif.in_clken = 1;
    repeat (2) @(posedge clk);
    #1;
    e_busy = 0; e_line = 0; e_frame = 0; e_bval = 0; e_mode = 0;
    sh_mode = 0; sh_bval = 0; e_row = 0;
    push_stat("in_reset", 0, 0, 0, 0, 0);
    rst = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    push_stat("post_reset_vs_high", 0, 0, 0, 1, 1);
    cyc(0, 0, 0);
    push_stat("post_reset_vs_low", 0, 0, 0, 1, 0);
    start_frame(0, 0, 0, 0);
    send_line(16, 0);

    repeat (3) cyc(0, 0, 0);
    stim_end = 1;
    for (int i = 0; i < 20 && !mon_fin; i++) @(posedge clk);
    if (!mon_fin) begin
      $display("FAIL monitor_timeout: monitor never finished");
      $fatal(1);
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
